pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REGW, default 5, register-address width.
REQ-002 SHALL have parameter MC_LAT, default 4, multicycle-op stall length in cycles; legal range 2..255.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_rs1, id_rs2  in  REGW  source registers of the instruction in ID.
REQ-006 SHALL have ports id_rs1_use, id_rs2_use  in  1  source actually read.
REQ-007 SHALL have port ex_rd  in  REGW  destination register of the instruction in EX.
REQ-008 SHALL have port ex_mem_read  in  1  EX instruction is a load.
REQ-009 SHALL have port ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-010 SHALL have port ex_mc_start  in  1  EX holds a multicycle op (mul/div) issuing this cycle.
REQ-011 SHALL have outputs stall_pc, stall_if_id, stall_id_ex  out  1  hold PC / IF-ID / ID-EX registers.
REQ-012 SHALL have outputs flush_if_id, flush_id_ex  out  1  zero IF-ID / ID-EX registers (bubble).
REQ-013 SHALL have outputs mc_busy, mc_done  out  1  FSM in MC_WAIT / final MC_WAIT cycle.

Function
REQ-014 SHALL implement FSM states IDLE and MC_WAIT plus an 8-bit down-counter mc_cnt.
REQ-015 SHALL compute all stall/flush outputs combinationally from state and current inputs (zero latency).
REQ-016 Load-use hazard SHALL be: ex_mem_read & ex_rd!=0 & ((id_rs1_use & id_rs1==ex_rd) | (id_rs2_use & id_rs2==ex_rd)).
REQ-017 IDLE, ex_mc_start=1: SHALL assert stall_pc, stall_if_id, stall_id_ex; load mc_cnt=MC_LAT-1; go MC_WAIT; branch and load-use ignored.
REQ-018 MC_WAIT, mc_cnt!=0: SHALL assert stall_pc, stall_if_id, stall_id_ex, mc_busy; decrement mc_cnt; all other inputs ignored.
REQ-019 MC_WAIT, mc_cnt==0: SHALL deassert stalls, assert mc_busy and mc_done, go IDLE; total stall exactly MC_LAT cycles.
REQ-020 IDLE, ex_branch_taken=1 (no mc start): SHALL assert flush_if_id and flush_id_ex for that cycle only; no stall; load-use suppressed.
REQ-021 IDLE, load-use only: SHALL assert stall_pc, stall_if_id, flush_id_ex for exactly one cycle (bubble); stall_id_ex=0.
REQ-022 Priority SHALL be MC_WAIT > ex_mc_start > ex_branch_taken > load-use.
REQ-023 Stall and flush on the same register SHALL never be asserted together.
REQ-024 ex_rd==0 SHALL never cause a load-use stall.

Reset
REQ-025 rst=1 SHALL force state IDLE, mc_cnt=0 immediately, independent of clk.
REQ-026 While rst=1 all outputs SHALL be 0; reset mid-MC_WAIT SHALL abort the op with no mc_done.
REQ-027 First edge after rst release SHALL evaluate normally from IDLE.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN SHALL, when defined, add outputs stall_cycles[31:0], flush_events[31:0], wrap-around counters cleared by rst.
REQ-029 stall_cycles SHALL increment each cycle stall_pc=1; flush_events SHALL increment each cycle flush_if_id=1.
REQ-030 Without HAZARD_PERF_CNT_EN the ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 Load x5 in EX, ID reads rs1=5 use=1 -> stall_pc=stall_if_id=flush_id_ex=1 one cycle, then all 0.
REQ-032 Same with ex_rd=0 or id_rs1_use=0 -> no stall, no flush.
REQ-033 ex_mc_start=1, MC_LAT=4 -> stalls high 4 cycles, mc_done=1 on 5th cycle with stalls 0.
REQ-034 ex_branch_taken=1 plus concurrent load-use -> flush_if_id=flush_id_ex=1, stall_pc=0, one cycle.
REQ-035 rst=1 asynchronously in MC_WAIT with mc_cnt=2 -> outputs 0 before next edge, IDLE afterwards, no mc_done.
REQ-036 HAZARD_PERF_CNT_EN, one MC op (MC_LAT=4) + one branch -> stall_cycles=4, flush_events=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a five-stage in-order pipeline. Decides each cycle
//   whether to hold or bubble the front end because of a multicycle EX op
//   (mul/div), a taken branch resolved in EX, or a load-use dependency
//   between the EX load and the ID instruction.
//
// State table
//   state   | meaning
//   IDLE    | normal issue; branch / load-use / mc-start evaluated each cycle
//   MC_WAIT | multicycle op in flight; front end held until mc_cnt reaches 0
//
// Parameters
//   REGW    register-address width
//   MC_LAT  multicycle-op stall length in cycles (2..255)
//
// Ports
//   clk, rst                       clock, async active-high reset
//   id_rs1/id_rs2, *_use           ID source registers and read-enables
//   ex_rd, ex_mem_read             EX destination, EX is a load
//   ex_branch_taken                EX resolved a taken branch/jump
//   ex_mc_start                    EX issues a multicycle op this cycle
//   stall_pc/stall_if_id/stall_id_ex   hold requests
//   flush_if_id/flush_id_ex        bubble requests
//   mc_busy, mc_done               in MC_WAIT / final MC_WAIT cycle
//   stall_cycles, flush_events     perf counters (HAZARD_PERF_CNT_EN only)
//
// Build option
//   HAZARD_PERF_CNT_EN  adds the two 32-bit wrap-around perf counters.

module pipe_hazard_ctrl #(
    parameter int REGW   = 5,
    parameter int MC_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_rs1_use,
    input  logic            id_rs2_use,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic            ex_mc_start,
    output logic            stall_pc,
    output logic            stall_if_id,
    output logic            stall_id_ex,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            mc_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic            mc_done,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_events
`else
    output logic            mc_done
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    // The start cycle itself is the first stall cycle, so the counter is
    // preloaded with MC_LAT-1 and the final (count==0) cycle releases.
    localparam logic [7:0] MC_LOAD = 8'(MC_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_mc_cnt;
    logic [7:0] w_mc_cnt_nxt;
    logic       w_load_use;

    assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                        ((id_rs1_use && (id_rs1 == ex_rd)) ||
                         (id_rs2_use && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mc_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;

        // Outputs are forced low for the whole reset window, even though
        // the data-path inputs may still show a hazard.
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (ex_mc_start) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        w_mc_cnt_nxt = MC_LOAD;
                        w_state_nxt  = MC_WAIT;
                    end else if (ex_branch_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (w_load_use) begin
                        // Hold fetch/decode, inject a bubble into EX.
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    if (r_mc_cnt != 8'd0) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        w_mc_cnt_nxt = r_mc_cnt - 8'd1;
                    end else begin
                        mc_done     = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_mc_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (stall_pc) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush_if_id) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REGW   = 5;
    localparam int MC_LAT = 4;

    logic            clk;
    logic            rst;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic            id_rs1_use;
    logic            id_rs2_use;
    logic [REGW-1:0] ex_rd;
    logic            ex_mem_read;
    logic            ex_branch_taken;
    logic            ex_mc_start;
    logic            stall_pc;
    logic            stall_if_id;
    logic            stall_id_ex;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            mc_busy;
    logic            mc_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     flush_events;
`endif

    pipe_hazard_ctrl #(.REGW(REGW), .MC_LAT(MC_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_use      (id_rs1_use),
        .id_rs2_use      (id_rs2_use),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .mc_busy         (mc_busy),
`ifdef HAZARD_PERF_CNT_EN
        .mc_done         (mc_done),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`else
        .mc_done         (mc_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mc_busy, mc_done}
    logic [6:0] outs;
    assign outs = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mc_busy, mc_done};

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: number of post-start wait cycles still to go
    // (MC_LAT after the start cycle, the last of which is the done cycle).
    int          m_wait_left = 0;
    int unsigned m_stalls    = 0;
    int unsigned m_flushes   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] model_out();
        logic lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
        if (m_wait_left > 1)  return 7'b1110010;
        if (m_wait_left == 1) return 7'b0000011;
        if (ex_mc_start)      return 7'b1110000;
        if (ex_branch_taken)  return 7'b0001100;
        if (lu)               return 7'b1100100;
        return 7'b0000000;
    endfunction

    task automatic model_edge();
        logic [6:0] e;
        e = model_out();
        if (e[6]) m_stalls++;
        if (e[3]) m_flushes++;
        if (m_wait_left > 0) m_wait_left--;
        else if (ex_mc_start) m_wait_left = MC_LAT;
    endtask

    task automatic model_reset();
        m_wait_left = 0;
        m_stalls    = 0;
        m_flushes   = 0;
    endtask

    task automatic clr_in();
        id_rs1 = '0; id_rs2 = '0; id_rs1_use = 1'b0; id_rs2_use = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
    endtask

    task automatic set_lu(input logic [REGW-1:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_rs1_use = 1'b1;
    endtask

    // Called just after a negedge with inputs already set.
    task automatic cyc(input string tag);
        #1;
        chk(tag, {25'd0, outs}, {25'd0, model_out()});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cycles, m_stalls);
        chk({tag, "_flush_cnt"}, flush_events, m_flushes);
`endif
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        // Reset window with a live load-use and mc-start on the inputs.
        rst = 1'b1;
        clr_in();
        set_lu(5'd5);
        ex_mc_start = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_outputs_zero", {25'd0, outs}, 32'd0);
        clr_in();
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Load-use on rs1: one bubble cycle, then quiet.
        set_lu(5'd5);
        #1;
        chk("load_use_vec", {25'd0, outs}, {25'd0, 7'b1100100});
        #1;
        cyc("load_use_rs1");
        clr_in();
        cyc("after_load_use");

        // Load-use through rs2.
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_use = 1'b1;
        cyc("load_use_rs2");
        clr_in();

        // No hazard: x0 destination, unused source, non-load.
        set_lu(5'd0);
        cyc("rd_zero");
        set_lu(5'd5); id_rs1_use = 1'b0;
        cyc("rs1_unused");
        set_lu(5'd5); ex_mem_read = 1'b0;
        cyc("not_a_load");
        clr_in();

        // Multicycle op; hazards present during the wait must be ignored.
        ex_mc_start = 1'b1;
        #1;
        chk("mc_start_vec", {25'd0, outs}, {25'd0, 7'b1110000});
        #1;
        cyc("mc_start");
        ex_mc_start = 1'b0;
        set_lu(5'd3);
        ex_branch_taken = 1'b1;
        for (int i = 0; i < MC_LAT; i++) cyc("mc_wait");
        clr_in();
        cyc("mc_after");

        // Branch beats a concurrent load-use.
        set_lu(5'd9);
        ex_branch_taken = 1'b1;
        #1;
        chk("branch_vec", {25'd0, outs}, {25'd0, 7'b0001100});
        #1;
        cyc("branch_over_lu");
        clr_in();
        cyc("branch_after");

        // mc-start beats branch.
        ex_mc_start = 1'b1; ex_branch_taken = 1'b1;
        cyc("mc_over_branch");
        clr_in();
        for (int i = 0; i < MC_LAT; i++) cyc("mc_wait2");

        // Async reset two cycles into the wait (counter at 2).
        ex_mc_start = 1'b1;
        cyc("mc_start_rst");
        clr_in();
        cyc("mc_wait_rst0");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {25'd0, outs}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MC_LAT + 1; i++) cyc("post_rst_idle");

`ifdef HAZARD_PERF_CNT_EN
        // One MC op plus one branch from freshly reset counters.
        ex_mc_start = 1'b1;
        cyc("perf_mc");
        clr_in();
        for (int i = 0; i < MC_LAT; i++) cyc("perf_wait");
        ex_branch_taken = 1'b1;
        cyc("perf_branch");
        clr_in();
        #1;
        chk("perf_stall_cycles", stall_cycles, 32'd4);
        chk("perf_flush_events", flush_events, 32'd1);
        @(negedge clk);
`endif

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            id_rs1          = REGW'($urandom_range(0, 3));
            id_rs2          = REGW'($urandom_range(0, 3));
            id_rs1_use      = 1'($urandom_range(0, 1));
            id_rs2_use      = 1'($urandom_range(0, 1));
            ex_rd           = REGW'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            ex_mc_start     = ($urandom_range(0, 99) < 8);
            cyc("random");
        end
        clr_in();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
